// File: rtl/eth_parser_pkg.sv
// Shared constants and types for the Ethernet receive-side parsers.
package eth_parser_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;
  localparam logic [3:0]  IPV4_VERSION   = 4'h4;

  // Byte offsets from the start-of-frame byte for an untagged frame.
  localparam int unsigned ETH_TYPE_OFS = 12;
  localparam int unsigned IP_VER_OFS   = 14;
  localparam int unsigned IP_SRC_OFS   = 26;
  localparam int unsigned IP_DST_OFS   = 30;
  localparam int unsigned VLAN_LEN     = 4;

  typedef enum logic [1:0] {
    IDLE,
    ETH_HDR,
    IP_HDR,
    DRAIN
  } parse_state_t;

endpackage

// File: rtl/byte_field_capture.sv
// Shift-in accumulator for a multi-byte big-endian field at a given start offset.
// field_o already includes the current byte, so it is complete in the cycle done_o is high.
module byte_field_capture #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FIELD_W = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [CNT_W-1:0]   ofs_i,
  input  logic [CNT_W-1:0]   start_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic               done_o,
  output logic [FIELD_W-1:0] field_o
);

  localparam int unsigned NBYTES = FIELD_W / DATA_W;
  localparam int unsigned ACC_W  = FIELD_W - DATA_W;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] last_ofs;
  logic             in_window;

  assign last_ofs  = start_i + CNT_W'(NBYTES - 1);
  assign in_window = en_i && (ofs_i >= start_i) && (ofs_i <= last_ofs);
  assign done_o    = en_i && (ofs_i == last_ofs);
  assign field_o   = {acc_q, data_i};

  always_comb begin
    acc_d = acc_q;
    if (in_window) begin
      acc_d = {acc_q[ACC_W-DATA_W-1:0], data_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ipv4_addr_extractor.sv
// Extracts IPv4 source/destination addresses from a received Ethernet byte stream.
// Define VLAN_TAG_EN to accept a single 802.1Q tag ahead of the IPv4 EtherType.
module ipv4_addr_extractor #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned IP_ADDR_W = 32,
  parameter int unsigned CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 valid_i,
  input  logic                 sof_i,
  input  logic                 eof_i,
  output logic                 insert_val_o,
  output logic                 look_up_val_o,
  output logic [IP_ADDR_W-1:0] ip_addr_o
);

  import eth_parser_pkg::*;

  localparam logic [CNT_W-1:0] OFS_ETYPE_HI = CNT_W'(ETH_TYPE_OFS);
  localparam logic [CNT_W-1:0] OFS_ETYPE_LO = CNT_W'(ETH_TYPE_OFS + 1);
  localparam logic [CNT_W-1:0] OFS_VER      = CNT_W'(IP_VER_OFS);
  localparam logic [CNT_W-1:0] OFS_SRC      = CNT_W'(IP_SRC_OFS);
  localparam logic [CNT_W-1:0] OFS_DST      = CNT_W'(IP_DST_OFS);

  parse_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    etype_hi_q, etype_hi_d;
  logic                 insert_q, insert_d;
  logic                 look_up_q, look_up_d;
  logic [IP_ADDR_W-1:0] ip_addr_q, ip_addr_d;

  logic [CNT_W-1:0]     shift;
  logic [CNT_W-1:0]     etype_hi_ofs, etype_lo_ofs, ver_ofs, src_start, dst_start;
  logic                 cap_en;
  logic                 src_done, dst_done;
  logic [IP_ADDR_W-1:0] src_field, dst_field;

`ifdef VLAN_TAG_EN
  logic vlan_q, vlan_d;
  assign shift = vlan_q ? CNT_W'(VLAN_LEN) : '0;
`else
  assign shift = '0;
`endif

  // Once a tag is seen every later field moves by the tag length.
  assign etype_hi_ofs = OFS_ETYPE_HI + shift;
  assign etype_lo_ofs = OFS_ETYPE_LO + shift;
  assign ver_ofs      = OFS_VER + shift;
  assign src_start    = OFS_SRC + shift;
  assign dst_start    = OFS_DST + shift;

  assign cap_en = valid_i && !sof_i && (state_q == IP_HDR);

  byte_field_capture #(
    .DATA_W  (DATA_W),
    .FIELD_W (IP_ADDR_W),
    .CNT_W   (CNT_W)
  ) u_src_cap (
    .clk     (clk),
    .rst     (rst),
    .en_i    (cap_en),
    .ofs_i   (cnt_q),
    .start_i (src_start),
    .data_i  (data_i),
    .done_o  (src_done),
    .field_o (src_field)
  );

  byte_field_capture #(
    .DATA_W  (DATA_W),
    .FIELD_W (IP_ADDR_W),
    .CNT_W   (CNT_W)
  ) u_dst_cap (
    .clk     (clk),
    .rst     (rst),
    .en_i    (cap_en),
    .ofs_i   (cnt_q),
    .start_i (dst_start),
    .data_i  (data_i),
    .done_o  (dst_done),
    .field_o (dst_field)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    etype_hi_d = etype_hi_q;
    insert_d   = 1'b0;
    look_up_d  = 1'b0;
    ip_addr_d  = ip_addr_q;
`ifdef VLAN_TAG_EN
    vlan_d     = vlan_q;
`endif
    if (valid_i) begin
      if (sof_i) begin
        // A new frame start wins over whatever was in progress.
        cnt_d   = CNT_W'(1);
        state_d = eof_i ? IDLE : ETH_HDR;
`ifdef VLAN_TAG_EN
        vlan_d  = 1'b0;
`endif
      end else begin
        if (state_q != IDLE) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
        case (state_q)
          ETH_HDR: begin
            if (cnt_q == etype_hi_ofs) begin
              etype_hi_d = data_i;
            end
            if (cnt_q == etype_lo_ofs) begin
              if ({etype_hi_q, data_i} == ETHERTYPE_IPV4) begin
                state_d = IP_HDR;
`ifdef VLAN_TAG_EN
              end else if (({etype_hi_q, data_i} == ETHERTYPE_VLAN) && !vlan_q) begin
                vlan_d = 1'b1;
`endif
              end else begin
                state_d = DRAIN;
              end
            end
          end
          IP_HDR: begin
            if ((cnt_q == ver_ofs) && (data_i[DATA_W-1 -: 4] != IPV4_VERSION)) begin
              state_d = DRAIN;
            end
            if (src_done) begin
              insert_d  = 1'b1;
              ip_addr_d = src_field;
            end
            if (dst_done) begin
              look_up_d = 1'b1;
              ip_addr_d = dst_field;
              state_d   = DRAIN;
            end
          end
          IDLE, DRAIN: ;
          default: state_d = IDLE;
        endcase
        // The last byte is processed first so a frame ending on an address byte still reports it.
        if (eof_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      etype_hi_q <= '0;
      insert_q   <= 1'b0;
      look_up_q  <= 1'b0;
      ip_addr_q  <= '0;
`ifdef VLAN_TAG_EN
      vlan_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      etype_hi_q <= etype_hi_d;
      insert_q   <= insert_d;
      look_up_q  <= look_up_d;
      ip_addr_q  <= ip_addr_d;
`ifdef VLAN_TAG_EN
      vlan_q     <= vlan_d;
`endif
    end
  end

  assign insert_val_o  = insert_q;
  assign look_up_val_o = look_up_q;
  assign ip_addr_o     = ip_addr_q;

endmodule

// File: tb/tb_ipv4_addr_extractor.sv
// Scoreboard bench for ipv4_addr_extractor: driver queues expected pulses, monitor checks them.
module tb_ipv4_addr_extractor;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned IP_ADDR_W = 32;
  localparam int unsigned CNT_W     = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DATA_W-1:0]    data_i;
  logic                 valid_i, sof_i, eof_i;
  logic                 insert_val_o, look_up_val_o;
  logic [IP_ADDR_W-1:0] ip_addr_o;

  always #5 clk = ~clk;

  ipv4_addr_extractor #(
    .DATA_W    (DATA_W),
    .IP_ADDR_W (IP_ADDR_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .sof_i         (sof_i),
    .eof_i         (eof_i),
    .insert_val_o  (insert_val_o),
    .look_up_val_o (look_up_val_o),
    .ip_addr_o     (ip_addr_o)
  );

  typedef struct packed {
    logic        lu;
    logic [31:0] addr;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  logic [7:0]  fb [0:99];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: flag overdue expectations, then match any presented pulse.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_pulse lu=%0b addr=%h due_cyc=%0d now=%0d", e.lu, e.addr, e.cyc, cyc);
    end
    if (insert_val_o || look_up_val_o) begin
      checks++;
      if (insert_val_o && look_up_val_o) begin
        failures++;
        $display("FAIL both_pulses ins=1 lu=1 required exactly one, cyc=%0d", cyc);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse ins=%0b lu=%0b addr=%h cyc=%0d required none",
                 insert_val_o, look_up_val_o, ip_addr_o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (look_up_val_o != e.lu || ip_addr_o != e.addr || cyc != e.cyc) begin
          failures++;
          $display("FAIL pulse got lu=%0b addr=%h cyc=%0d required lu=%0b addr=%h cyc=%0d",
                   look_up_val_o, ip_addr_o, cyc, e.lu, e.addr, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic s, input logic e, input logic r);
    data_i  = d;
    valid_i = 1'b1;
    sof_i   = s;
    eof_i   = e;
    rst     = r;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    sof_i   = 1'b0;
    eof_i   = 1'b0;
    rst     = 1'b0;
    data_i  = 8'h00;
  endtask

  // tags: 0 untagged, 1 single 802.1Q tag, 2 two stacked tags
  task automatic build(input logic [15:0] etype, input int tags, input logic [3:0] ver,
                       input logic [31:0] src, input logic [31:0] dst);
    int o;
    for (int i = 0; i < 100; i++) fb[i] = 8'(8'h5A ^ i);
    o = 4 * tags;
    for (int t = 0; t < tags; t++) begin
      fb[12 + 4*t] = 8'h81;
      fb[13 + 4*t] = 8'h00;
      fb[14 + 4*t] = 8'h00;
      fb[15 + 4*t] = 8'h05;
    end
    fb[12 + o] = etype[15:8];
    fb[13 + o] = etype[7:0];
    fb[14 + o] = {ver, 4'h5};
    for (int b = 0; b < 4; b++) begin
      fb[26 + o + b] = src[31 - 8*b -: 8];
      fb[30 + o + b] = dst[31 - 8*b -: 8];
    end
  endtask

  task automatic send(input int n, input bit gaps, input bit with_eof, input int rst_at,
                      input int ins_at, input int lu_at,
                      input logic [31:0] src, input logic [31:0] dst);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (i == ins_at) begin
        e.lu = 1'b0; e.addr = src; e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
      if (i == lu_at) begin
        e.lu = 1'b1; e.addr = dst; e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
      drive_byte(fb[i], i == 0, with_eof && (i == n - 1), i == rst_at);
      if (i == rst_at) begin
        chk("midframe_rst_insert",  {31'd0, insert_val_o},  32'd0);
        chk("midframe_rst_look_up", {31'd0, look_up_val_o}, 32'd0);
        chk("midframe_rst_ip_addr", ip_addr_o,               32'd0);
      end
      if (gaps) idle(1);
    end
    idle(2);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0; data_i = 8'h00;
    idle(3);
    rst = 1'b0;
    chk("reset_insert",  {31'd0, insert_val_o},  32'd0);
    chk("reset_look_up", {31'd0, look_up_val_o}, 32'd0);
    chk("reset_ip_addr", ip_addr_o,               32'd0);
    idle(2);

    // single-byte frame: sof and eof together
    drive_byte(8'h45, 1'b1, 1'b1, 1'b0);
    idle(2);

    build(16'h0800, 0, 4'h4, 32'h0A000001, 32'hC0A80107);
    send(60, 1'b0, 1'b1, -1, 29, 33, 32'h0A000001, 32'hC0A80107);
    send(60, 1'b1, 1'b1, -1, 29, 33, 32'h0A000001, 32'hC0A80107);

    build(16'h0806, 0, 4'h4, 32'h01020304, 32'h05060708);
    send(60, 1'b0, 1'b1, -1, -1, -1, 32'h0, 32'h0);
    build(16'h0800, 0, 4'h6, 32'h01020304, 32'h05060708);
    send(60, 1'b0, 1'b1, -1, -1, -1, 32'h0, 32'h0);

    // truncated at byte 31, then a full frame
    build(16'h0800, 0, 4'h4, 32'h0A000001, 32'hC0A80107);
    send(32, 1'b0, 1'b1, -1, 29, -1, 32'h0A000001, 32'h0);
    build(16'h0800, 0, 4'h4, 32'hAC100509, 32'h08080404);
    send(60, 1'b0, 1'b1, -1, 29, 33, 32'hAC100509, 32'h08080404);

    // frame A abandoned at byte 20 by a new sof; frame B completes
    build(16'h0800, 0, 4'h4, 32'h11111111, 32'h22222222);
    data_i = 8'h00;
    send(20, 1'b0, 1'b0, -1, -1, -1, 32'h0, 32'h0);
    build(16'h0800, 0, 4'h4, 32'hC0000201, 32'hC6336402);
    send(60, 1'b0, 1'b1, -1, 29, 33, 32'hC0000201, 32'hC6336402);

    // reset at byte 28 of frame C, then recovery
    build(16'h0800, 0, 4'h4, 32'h33333333, 32'h44444444);
    send(60, 1'b0, 1'b1, 28, -1, -1, 32'h0, 32'h0);
    build(16'h0800, 0, 4'h4, 32'h7F000001, 32'hFFFFFFFE);
    send(60, 1'b0, 1'b1, -1, 29, 33, 32'h7F000001, 32'hFFFFFFFE);

    build(16'h0800, 1, 4'h4, 32'h0A000001, 32'hC0A80107);
`ifdef VLAN_TAG_EN
    send(64, 1'b0, 1'b1, -1, 33, 37, 32'h0A000001, 32'hC0A80107);
`else
    send(64, 1'b0, 1'b1, -1, -1, -1, 32'h0, 32'h0);
`endif
    build(16'h0800, 2, 4'h4, 32'h0A000001, 32'hC0A80107);
    send(68, 1'b0, 1'b1, -1, -1, -1, 32'h0, 32'h0);

    // long frame drives the counter into saturation after the fields
    build(16'h0800, 0, 4'h4, 32'h0A0B0C0D, 32'h01020304);
    send(100, 1'b0, 1'b1, -1, 29, 33, 32'h0A0B0C0D, 32'h01020304);

    idle(4);
    chk("pending_expectations", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
